// File: rtl/ysyx_ifu_fetchq.sv
// Instruction fetch front end: single-outstanding sequential fetch into a small
// registered prefetch queue, flushed and restarted on a writeback redirect.
module ysyx_ifu_fetchq #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned     DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [XLEN-1:0]          mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [31:0]              mem_rsp_data,
  input  logic                     mem_rsp_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_KILL_REQ,
    S_KILL_WAIT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] req_addr;
  logic            halted;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_inst  [DEPTH];
  logic            q_fault [DEPTH];

  logic            flush_c;
  logic            pop_c;
  logic            enq_c;
  logic            room_c;
  logic [XLEN-1:0] fpc_next_c;
  logic [CW-1:0]   count_next_c;
  logic [PW-1:0]   rd_next_c;
  logic [PW-1:0]   wr_next_c;
  logic [XLEN-1:0] head_pc_c;
  logic [31:0]     head_inst_c;
  logic            head_fault_c;
  logic            unused_redirect_lsb_c;

  assign mem_req_addr          = req_addr;
  assign unused_redirect_lsb_c = ^redirect_pc[1:0];

  // Queue bookkeeping and the head entry that will be visible next cycle
  always_comb begin
    flush_c      = redirect_valid;
    pop_c        = out_valid && out_ready && !flush_c;
    enq_c        = (state == S_WAIT) && mem_rsp_valid && !flush_c;
    fpc_next_c   = fpc;
    if (flush_c)    fpc_next_c = {redirect_pc[XLEN-1:2], 2'b00};
    else if (enq_c) fpc_next_c = req_addr + XLEN'(4);
    count_next_c = flush_c ? '0 : fq_count + CW'(enq_c) - CW'(pop_c);
    rd_next_c    = flush_c ? '0 : rd_ptr + PW'(pop_c);
    wr_next_c    = flush_c ? '0 : wr_ptr + PW'(enq_c);
    room_c       = count_next_c < CW'(DEPTH);
    head_pc_c    = q_pc[rd_next_c];
    head_inst_c  = q_inst[rd_next_c];
    head_fault_c = q_fault[rd_next_c];
    // An entry written into the slot that becomes the head bypasses the array
    if (enq_c && (wr_ptr == rd_next_c)) begin
      head_pc_c    = req_addr;
      head_inst_c  = mem_rsp_data;
      head_fault_c = mem_rsp_err;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_c) begin
      q_pc[wr_ptr]    <= req_addr;
      q_inst[wr_ptr]  <= mem_rsp_data;
      q_fault[wr_ptr] <= mem_rsp_err;
    end
  end

  // Fetch FSM, queue pointers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_REQ;
      fpc           <= RESET_PC;
      req_addr      <= RESET_PC;
      halted        <= 1'b0;
      mem_req_valid <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fq_count      <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_inst      <= '0;
      out_fault     <= 1'b0;
    end else begin
      fpc       <= fpc_next_c;
      rd_ptr    <= rd_next_c;
      wr_ptr    <= wr_next_c;
      fq_count  <= count_next_c;
      out_valid <= count_next_c != '0;
      out_pc    <= head_pc_c;
      out_inst  <= head_inst_c;
      out_fault <= head_fault_c;
      if (flush_c)                  halted <= 1'b0;
      else if (enq_c && mem_rsp_err) halted <= 1'b1;

      case (state)
        S_IDLE: begin
          if (flush_c || (!halted && (fq_count < CW'(DEPTH)))) begin
            state         <= S_REQ;
            req_addr      <= fpc_next_c;
            mem_req_valid <= 1'b1;
          end
        end
        S_REQ: begin
          // Valid is low only in the first cycle out of reset: nothing is held yet
          if (!mem_req_valid) begin
            req_addr      <= fpc_next_c;
            mem_req_valid <= 1'b1;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= flush_c ? S_KILL_WAIT : S_WAIT;
          end else if (flush_c) begin
            state <= S_KILL_REQ;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (flush_c || (!mem_rsp_err && room_c)) begin
              state         <= S_REQ;
              req_addr      <= fpc_next_c;
              mem_req_valid <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else if (flush_c) begin
            state <= S_KILL_WAIT;
          end
        end
        S_KILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_KILL_WAIT;
          end
        end
        S_KILL_WAIT: begin
          if (mem_rsp_valid) begin
            state         <= S_REQ;
            req_addr      <= fpc_next_c;
            mem_req_valid <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_ifu_fetchq.md
Name: ysyx_ifu_fetchq

Overview:
- Instruction fetch front end with a small prefetch queue. Sits directly downstream of the writeback stage's redirect outputs (next PC plus retire/redirect strobe) and upstream of decode.
- Issues one sequential fetch at a time to the instruction memory port and buffers {pc, inst, fault} entries.
- On a redirect: flushes the queue, discards any in-flight response, and restarts fetch at the new PC.

Parameters:
- XLEN, 32: address/PC width.
- RESET_PC, 32'h8000_0000: first fetch address after reset.
- DEPTH, 4: queue entries; power of 2, ≥2.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  writeback retire/redirect strobe; load redirect_pc.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 00).
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  fetch address; stable while valid && !ready.
- mem_rsp_valid  in  1  response valid, one cycle, exactly one per accepted request.
- mem_rsp_data  in  32  instruction word.
- mem_rsp_err  in  1  access fault for this response.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  XLEN  PC of head entry.
- out_inst  out  32  instruction of head entry.
- out_fault  out  1  head entry is an access fault.
- fq_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset values: fpc=RESET_PC, state=REQ, queue empty, mem_req_valid=0, out_valid=0, out_pc/out_inst/out_fault=0, fq_count=0, halted=0. First request is asserted the cycle after reset deasserts.
- States:
  - IDLE: no request.
  - REQ: mem_req_valid=1, mem_req_addr=req_addr.
  - WAIT: one request outstanding.
  - KILL_REQ: request held; its response will be dropped.
  - KILL_WAIT: outstanding response will be dropped.
- Issue rule: leave IDLE for REQ only when !halted and fq_count + (pending response) < DEPTH, so an enqueue can never overflow. On entering REQ, req_addr <= fpc.
- REQ: on mem_req_ready go to WAIT. Never deassert valid or change address before ready.
- WAIT: on mem_rsp_valid:
  - Enqueue {req_addr, mem_rsp_data, mem_rsp_err}.
  - fpc <= req_addr+4, with XLEN wrap-around and no carry-out.
  - If err: halted <= 1 and go to IDLE.
  - Otherwise go to REQ if space remains after this enqueue and any same-cycle dequeue, else IDLE.
- Response latency: a response accepted at cycle r is visible at the queue output at r+1 (registered queue).
- Dequeue: out_valid = (fq_count != 0). An entry is popped when out_valid && out_ready. Enqueue and dequeue in the same cycle leave the count unchanged. Read/write pointers wrap modulo DEPTH.
- Redirect (redirect_valid=1), highest priority:
  - Queue flushed: count=0, pointers reset, out_valid=0 next cycle even if out_ready was high the same cycle.
  - fpc <= {redirect_pc[XLEN-1:2],2'b00}; halted <= 0.
  - IDLE → REQ next cycle with the new address (request at t+1).
  - REQ with mem_req_ready=0 → KILL_REQ.
  - REQ with mem_req_ready=1 → KILL_WAIT.
  - WAIT without a response → KILL_WAIT.
  - WAIT with a same-cycle response → response dropped, REQ.
  - KILL_REQ/KILL_WAIT stay in place; only fpc is updated.
- KILL_REQ: on ready → KILL_WAIT.
- KILL_WAIT: on mem_rsp_valid, drop the data (never enqueued) and go to REQ with the latest fpc.
- Back-to-back redirects: the last one wins.
- Reset mid-operation returns to reset values immediately. The memory port is reset by the same reset, so no stale response is expected.

Test Plan:
- Reset release, ready=1, 1-cycle response latency, out_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008; out_pc follows in order with matching out_inst.
- out_ready=0, DEPTH=4 → exactly 4 entries filled, fq_count=4, mem_req_valid stays 0. Asserting out_ready for one cycle → one new request is issued.
- Redirect to 0x80001002 while in WAIT → response dropped, next request addr 0x80001000, queue empty the cycle after the redirect.
- mem_req_ready held low 3 cycles with a redirect in cycle 2 → addr unchanged until accepted; that response is discarded; then a request to the redirect PC is issued.
- mem_rsp_err=1 on 0x80000010 → entry with out_fault=1, no further requests; redirect to 0x80000100 resumes fetch.
- Redirect in the same cycle as a response and out_ready → nothing from the dropped response is enqueued, fq_count=0, next request is to the redirect PC.
